// File: rtl/pc_fetch_gen_pkg.sv
// Shared types for the fetch-address generator: FSM states, redirect sources
// and the fetch step helper.
package pc_fetch_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } pcgen_state_t;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_ID   = 2'd1,
    REDIR_EX   = 2'd2
  } redir_src_t;

  function automatic int unsigned fetch_step(input int unsigned fetch_n,
                                             input int unsigned instr_bytes);
    return fetch_n * instr_bytes;
  endfunction

endpackage

// File: rtl/pc_fetch_gen_if.sv
// Instruction-memory request/grant bus between the fetch generator (master)
// and the instruction memory (slave).
interface pc_fetch_gen_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_gnt_i;

  modport master (output imem_req_o, output imem_addr_o, input imem_gnt_i);
  modport slave  (input imem_req_o, input imem_addr_o, output imem_gnt_i);
endinterface

// File: rtl/pc_fetch_gen_redirect_arb.sv
// Combinational EX-over-ID redirect select with target alignment handling.
// PCGEN_MISALIGN_CHK_EN: discard misaligned targets and flag them instead of masking.
module pcgen_redirect_arb
  import pc_fetch_gen_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int unsigned INSTR_BYTES = 4
) (
  input  logic              ex_en,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              id_en,
  input  logic [ADDR_W-1:0] id_pc,
  output redir_src_t        src,
  output logic              take,
  output logic [ADDR_W-1:0] target,
  output logic              misalign
);

  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INSTR_BYTES - 1);

  logic [ADDR_W-1:0] raw;

  // EX redirects come from the older instruction, so they win over ID jumps.
  always_comb begin
    src = REDIR_NONE;
    raw = '0;
    if (ex_en) begin
      src = REDIR_EX;
      raw = ex_pc;
    end else if (id_en) begin
      src = REDIR_ID;
      raw = id_pc;
    end
  end

`ifdef PCGEN_MISALIGN_CHK_EN
  assign misalign = (src != REDIR_NONE) && ((raw & LOW_MASK) != '0);
  assign take     = (src != REDIR_NONE) && !misalign;
  assign target   = raw;
`else
  assign misalign = 1'b0;
  assign take     = (src != REDIR_NONE);
  assign target   = raw & ~LOW_MASK;
`endif

endmodule

// File: rtl/pc_fetch_gen.sv
// Fetch-address generator: owns the fetch PC, runs the imem request/grant
// handshake and buffers redirects that arrive while a request is pending.
// Optional misaligned-target check: define PCGEN_MISALIGN_CHK_EN.
module pc_fetch_gen
  import pc_fetch_gen_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       INSTR_BYTES = 4,
  parameter int unsigned       FETCH_N     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_redirect_en_i,
  input  logic [ADDR_W-1:0]  ex_redirect_pc_i,
  input  logic               id_jump_en_i,
  input  logic [ADDR_W-1:0]  id_jump_pc_i,
  input  logic               stall_i,
  pc_fetch_gen_if.master     imem,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               pc_valid_o,
  output logic               misalign_o
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(fetch_step(FETCH_N, INSTR_BYTES));

  pcgen_state_t      state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pc_d;
  logic              valid_d;
  logic              mis_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

  redir_src_t        redir_src;
  logic              redir_take;
  logic              redir_any;
  logic [ADDR_W-1:0] redir_pc;
  logic              redir_misalign;

  pcgen_redirect_arb #(
    .ADDR_W      (ADDR_W),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_arb (
    .ex_en    (ex_redirect_en_i),
    .ex_pc    (ex_redirect_pc_i),
    .id_en    (id_jump_en_i),
    .id_pc    (id_jump_pc_i),
    .src      (redir_src),
    .take     (redir_take),
    .target   (redir_pc),
    .misalign (redir_misalign)
  );

  // A discarded misaligned redirect still counts here, so its grant is killed.
  assign redir_any = (redir_src != REDIR_NONE);

  assign imem.imem_req_o  = req_q;
  assign imem.imem_addr_o = addr_q;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    addr_d       = addr_q;
    pc_d         = pc_o;
    valid_d      = 1'b0;
    mis_d        = redir_misalign;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;

    case (state_q)
      IDLE: begin
        if (redir_take) begin
          addr_d = redir_pc;
        end
        if (!stall_i) begin
          state_d = REQ;
          req_d   = 1'b1;
        end
      end
      REQ: begin
        if (imem.imem_gnt_i) begin
          pc_d         = addr_q;
          valid_d      = !(redir_any || pend_valid_q);
          pend_valid_d = 1'b0;
          if (redir_take) begin
            addr_d = redir_pc;
          end else if (pend_valid_q) begin
            addr_d = pend_pc_q;
          end else begin
            addr_d = addr_q + STEP;
          end
          if (stall_i) begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end else if (redir_take) begin
          // Address must stay stable until grant; remember the newest target.
          pend_valid_d = 1'b1;
          pend_pc_d    = redir_pc;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
      pc_o         <= RESET_PC;
      pc_valid_o   <= 1'b0;
      misalign_o   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      pc_o         <= pc_d;
      pc_valid_o   <= valid_d;
      misalign_o   <= mis_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Self-checking bench for pc_fetch_gen: per-cycle vector table with a grant
// scoreboard, plus fixed-grant instances for FETCH_N=2 and a wrapping reset PC.
module tb_pc_fetch_gen;

  typedef struct {
    logic        stall;
    logic        gnt;
    logic        ex_en;
    logic [31:0] ex_pc;
    logic        id_en;
    logic [31:0] id_pc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_kill;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
  } sb_t;

`ifdef PCGEN_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        ex_en, id_en, stall;
  logic [31:0] ex_pc, id_pc;
  logic [31:0] pc;
  logic        pc_valid, misalign;
  logic [31:0] pc_n2, pc_wr;
  logic        valid_n2, valid_wr, mis_n2, mis_wr;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  sb_t  sb[$];

  pc_fetch_gen_if #(.ADDR_W(32)) bus ();
  pc_fetch_gen_if #(.ADDR_W(32)) bus_n2 ();
  pc_fetch_gen_if #(.ADDR_W(32)) bus_wr ();

  assign bus_n2.imem_gnt_i = 1'b1;
  assign bus_wr.imem_gnt_i = 1'b1;

  pc_fetch_gen #(.ADDR_W(32), .RESET_PC(32'h0), .INSTR_BYTES(4), .FETCH_N(1)) dut (
    .clk(clk), .rst(rst),
    .ex_redirect_en_i(ex_en), .ex_redirect_pc_i(ex_pc),
    .id_jump_en_i(id_en), .id_jump_pc_i(id_pc),
    .stall_i(stall), .imem(bus.master),
    .pc_o(pc), .pc_valid_o(pc_valid), .misalign_o(misalign)
  );

  pc_fetch_gen #(.ADDR_W(32), .RESET_PC(32'h0), .INSTR_BYTES(4), .FETCH_N(2)) dut_n2 (
    .clk(clk), .rst(rst),
    .ex_redirect_en_i(1'b0), .ex_redirect_pc_i(32'h0),
    .id_jump_en_i(1'b0), .id_jump_pc_i(32'h0),
    .stall_i(1'b0), .imem(bus_n2.master),
    .pc_o(pc_n2), .pc_valid_o(valid_n2), .misalign_o(mis_n2)
  );

  pc_fetch_gen #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8), .INSTR_BYTES(4), .FETCH_N(1)) dut_wr (
    .clk(clk), .rst(rst),
    .ex_redirect_en_i(1'b0), .ex_redirect_pc_i(32'h0),
    .id_jump_en_i(1'b0), .id_jump_pc_i(32'h0),
    .stall_i(1'b0), .imem(bus_wr.master),
    .pc_o(pc_wr), .pc_valid_o(valid_wr), .misalign_o(mis_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare pc_o/pc_valid_o against the fetch granted one cycle earlier.
  task automatic check_scoreboard(input int idx);
    sb_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_output($sformatf("v%0d pc_o", idx), pc, e.pc);
      check_output($sformatf("v%0d pc_valid_o", idx), {31'b0, pc_valid}, {31'b0, e.valid});
    end else begin
      check_output($sformatf("v%0d pc_valid_o idle", idx), {31'b0, pc_valid}, 32'h0);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    sb_t e;
    stall          = v.stall;
    bus.imem_gnt_i = v.gnt;
    ex_en          = v.ex_en;
    ex_pc          = v.ex_pc;
    id_en          = v.id_en;
    id_pc          = v.id_pc;
    if (v.gnt && v.exp_req) begin
      e.pc    = v.exp_addr;
      e.valid = !v.exp_kill;
      sb.push_back(e);
    end
  endtask

  initial begin
    // stall gnt ex_en ex_pc id_en id_pc exp_req exp_addr kill mis
    vecs.push_back('{0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0});
    vecs.push_back('{0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h0,   0, 0});
    vecs.push_back('{0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h4,   0, 0});
    vecs.push_back('{0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h8,   0, 0});
    vecs.push_back('{0, 1, 0, 32'h0,   0, 32'h0,   1, 32'hC,   0, 0});
    vecs.push_back('{0, 1, 1, 32'h100, 1, 32'h200, 1, 32'h10,  1, 0});
    vecs.push_back('{0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 0});
    vecs.push_back('{0, 0, 0, 32'h0,   1, 32'h40,  1, 32'h104, 0, 0});
    vecs.push_back('{0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h104, 0, 0});
    vecs.push_back('{0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h104, 0, 0});
    vecs.push_back('{0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h104, 1, 0});
    vecs.push_back('{1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h40,  0, 0});
    vecs.push_back('{1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h44,  0, 0});
    vecs.push_back('{1, 0, 1, 32'h80,  0, 32'h0,   0, 32'h44,  0, 0});
    vecs.push_back('{1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h80,  0, 0});
    vecs.push_back('{0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h80,  0, 0});
    vecs.push_back('{0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 0});
    vecs.push_back('{1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h84,  0, 0});
    vecs.push_back('{0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h84,  0, 0});
    vecs.push_back('{0, 1, 0, 32'h0,   1, 32'h42,  1, 32'h88,  1, 0});
    vecs.push_back('{0, 1, 0, 32'h0,   0, 32'h0,   1, (CHK ? 32'h8C : 32'h40), 0, CHK});
    vecs.push_back('{0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, (CHK ? 32'h90 : 32'h44), 1, 0});
    vecs.push_back('{0, 1, 0, 32'h0,   0, 32'h0,   1, 32'hFFFF_FFFC, 0, 0});
    vecs.push_back('{1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h0,   0, 0});
    vecs.push_back('{0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h0,   0, 0});

    rst = 1'b1;
    stall = 1'b0;
    ex_en = 1'b0;
    id_en = 1'b0;
    ex_pc = '0;
    id_pc = '0;
    bus.imem_gnt_i = 1'b0;
    repeat (2) @(negedge clk);

    check_output("reset req",      {31'b0, bus.imem_req_o}, 32'h0);
    check_output("reset addr",     bus.imem_addr_o, 32'h0);
    check_output("reset pc",       pc, 32'h0);
    check_output("reset valid",    {31'b0, pc_valid}, 32'h0);
    check_output("reset misalign", {31'b0, misalign}, 32'h0);
    check_output("reset wrap addr", bus_wr.imem_addr_o, 32'hFFFF_FFF8);
    check_output("reset wrap pc",   pc_wr, 32'hFFFF_FFF8);
    check_output("reset aux misalign", {30'b0, mis_n2, mis_wr}, 32'h0);

    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      check_scoreboard(i);
      check_output($sformatf("v%0d req", i), {31'b0, bus.imem_req_o}, {31'b0, vecs[i].exp_req});
      check_output($sformatf("v%0d addr", i), bus.imem_addr_o, vecs[i].exp_addr);
      check_output($sformatf("v%0d misalign", i), {31'b0, misalign}, {31'b0, vecs[i].exp_mis});
      if (i >= 1 && i <= 4) begin
        check_output($sformatf("n2 addr c%0d", i), bus_n2.imem_addr_o, 32'((i - 1) * 8));
        check_output($sformatf("wrap addr c%0d", i), bus_wr.imem_addr_o,
                     32'hFFFF_FFF8 + 32'((i - 1) * 4));
      end
      if (i >= 2 && i <= 5) begin
        check_output($sformatf("aux valid c%0d", i), {30'b0, valid_n2, valid_wr}, 32'h3);
        check_output($sformatf("n2 pc c%0d", i), pc_n2, 32'((i - 2) * 8));
      end
      apply_stimulus(vecs[i]);
      @(posedge clk);
      @(negedge clk);
    end
    check_scoreboard(vecs.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
